// File: rtl/cpu_seq_pkg.sv
// Shared types and encodings for the CPU sequencer.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_EXECUTE    = 3'd1,
    S_MEM_WAIT   = 3'd2,
    S_WAIT_EVENT = 3'd3,
    S_WRITE_BACK = 3'd4,
    S_HALT       = 3'd5
  } state_t;

  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_JMP   = 4'd2;
  localparam logic [3:0] OP_BEQ   = 4'd3;
  localparam logic [3:0] OP_BNE   = 4'd4;
  localparam logic [3:0] OP_WAIT  = 4'd7;
  localparam logic [3:0] OP_ADDI  = 4'd8;
  localparam logic [3:0] OP_ANDI  = 4'd9;
  localparam logic [3:0] OP_ADDI2 = 4'd10;
  localparam logic [3:0] OP_RAND  = 4'd11;
  localparam logic [3:0] OP_STORE = 4'd13;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd5;

  localparam logic [1:0] RWS_ALU  = 2'b00;
  localparam logic [1:0] RWS_MEM  = 2'b01;
  localparam logic [1:0] RWS_RAND = 2'b10;

  typedef struct packed {
    logic [3:0] op;
    logic       src;
  } alu_steer_t;

  // ALU operation and B-operand select for a given opcode.
  function automatic alu_steer_t alu_steer(input logic [3:0] opcode,
                                           input logic [3:0] func);
    alu_steer_t s;
    s = '0;
    case (opcode)
      OP_ALU:                             s = '{op: func,    src: 1'b0};
      OP_BEQ, OP_BNE:                     s = '{op: ALU_SUB, src: 1'b0};
      OP_ADDI, OP_ADDI2, OP_STORE, OP_LOAD: s = '{op: ALU_ADD, src: 1'b1};
      OP_ANDI:                            s = '{op: ALU_AND, src: 1'b1};
      default:                            s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         sys_clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at all-ones.
  always_ff @(posedge sys_clock) begin
    if (!reset_n)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch/execute/memory/event-wait/write-back/halt.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int N_EVENTS = 2,
  parameter int TIMEOUT  = 0,
  parameter int CNT_W    = 16,
  localparam int EV_W    = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                sys_clock,
  input  logic                reset_n,
  input  logic [3:0]          opcode,
  input  logic [3:0]          alu_func,
  input  logic [EV_W-1:0]     ev_sel,
  input  logic                zero_flag,
  input  logic [N_EVENTS-1:0] event_pulse,
  input  logic                data_mem_ready,
  input  logic                resume,
  output logic                pc_en,
  output logic                do_jump,
  output logic                w_en,
  output logic [3:0]          alu_op_sel,
  output logic                alu_src,
  output logic [1:0]          reg_write_src,
  output logic                data_mem_req,
  output logic                data_mem_w_en,
  output logic                halted,
  output logic                wait_timeout,
  output logic [CNT_W-1:0]    instr_count,
  output logic [CNT_W-1:0]    stall_count,
  output logic [2:0]          state_o
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = (TIMEOUT > 0) ? WC_W'(TIMEOUT - 1) : '0;

  state_t          state;
  logic            pend;
  logic [WC_W-1:0] wait_cnt;
  logic            sel_pulse;
  logic            sel_valid;
  alu_steer_t      steer;

  // Pick the selected event strobe; an out-of-range select is flagged invalid.
  always_comb begin
    sel_pulse = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < N_EVENTS; i++) begin
      if (ev_sel == EV_W'(i)) begin
        sel_pulse = event_pulse[i];
        sel_valid = 1'b1;
      end
    end
  end

  // State register, pending-event flag, wait counter and sticky timeout.
  always_ff @(posedge sys_clock) begin
    if (!reset_n) begin
      state        <= S_FETCH;
      pend         <= 1'b0;
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_EXECUTE;
        S_EXECUTE: begin
          wait_cnt <= '0;
          pend     <= (opcode == OP_WAIT) && sel_pulse;
          case (opcode)
            OP_WAIT:           state <= S_WAIT_EVENT;
            OP_STORE, OP_LOAD: state <= S_MEM_WAIT;
            OP_HALT:           state <= S_HALT;
            default:           state <= S_WRITE_BACK;
          endcase
        end
        S_MEM_WAIT: if (data_mem_ready) state <= S_WRITE_BACK;
        S_WAIT_EVENT: begin
          if (!sel_valid || pend || sel_pulse) begin
            state <= S_WRITE_BACK;
          end else if ((TIMEOUT > 0) && (wait_cnt == WC_LAST)) begin
            state        <= S_WRITE_BACK;
            wait_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WRITE_BACK: state <= S_FETCH;
        S_HALT:       if (resume) state <= S_FETCH;
        default:      state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state plus live inputs so HALT can raise pc_en in the resume cycle.
  always_comb begin
    steer         = alu_steer(opcode, alu_func);
    pc_en         = 1'b0;
    do_jump       = 1'b0;
    w_en          = 1'b0;
    alu_op_sel    = '0;
    alu_src       = 1'b0;
    reg_write_src = RWS_ALU;
    data_mem_req  = 1'b0;
    data_mem_w_en = 1'b0;
    halted        = 1'b0;
    case (state)
      S_EXECUTE, S_WAIT_EVENT: begin
        alu_op_sel = steer.op;
        alu_src    = steer.src;
      end
      S_MEM_WAIT: begin
        alu_op_sel    = steer.op;
        alu_src       = steer.src;
        data_mem_req  = 1'b1;
        data_mem_w_en = (opcode == OP_STORE);
      end
      S_WRITE_BACK: begin
        alu_op_sel = steer.op;
        alu_src    = steer.src;
        pc_en      = 1'b1;
        w_en       = (opcode == OP_ALU) || (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                     (opcode == OP_ADDI2) || (opcode == OP_RAND) || (opcode == OP_LOAD);
        if (opcode == OP_LOAD)      reg_write_src = RWS_MEM;
        else if (opcode == OP_RAND) reg_write_src = RWS_RAND;
        do_jump    = (opcode == OP_JMP) || ((opcode == OP_BEQ) && zero_flag) ||
                     ((opcode == OP_BNE) && !zero_flag);
      end
      S_HALT: begin
        halted = 1'b1;
        pc_en  = resume;
      end
      default: ;
    endcase
  end

  assign state_o = state;

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .inc       (state == S_WRITE_BACK),
    .count     (instr_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .inc       ((state == S_MEM_WAIT) || (state == S_WAIT_EVENT)),
    .count     (stall_count)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: driver pushes expected retire records, monitor checks them.
module tb_cpu_sequencer;

  localparam int NEV   = 3;
  localparam int TMO   = 10;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic           sys_clock;
  logic           reset_n;
  logic [3:0]     opcode;
  logic [3:0]     alu_func;
  logic [1:0]     ev_sel;
  logic           zero_flag;
  logic [NEV-1:0] event_pulse;
  logic           data_mem_ready;
  logic           resume;
  logic           pc_en, do_jump, w_en, alu_src, data_mem_req, data_mem_w_en, halted, wait_timeout;
  logic [3:0]     alu_op_sel;
  logic [1:0]     reg_write_src;
  logic [CW-1:0]  instr_count, stall_count;
  logic [2:0]     state_o;

  cpu_sequencer #(.N_EVENTS(NEV), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .opcode(opcode), .alu_func(alu_func),
    .ev_sel(ev_sel), .zero_flag(zero_flag), .event_pulse(event_pulse),
    .data_mem_ready(data_mem_ready), .resume(resume), .pc_en(pc_en), .do_jump(do_jump),
    .w_en(w_en), .alu_op_sel(alu_op_sel), .alu_src(alu_src), .reg_write_src(reg_write_src),
    .data_mem_req(data_mem_req), .data_mem_w_en(data_mem_w_en), .halted(halted),
    .wait_timeout(wait_timeout), .instr_count(instr_count), .stall_count(stall_count),
    .state_o(state_o)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  typedef struct {
    logic [3:0] op;
    logic       jump;
    logic       wen;
    logic [1:0] rws;
    logic [3:0] alu;
    logic       src;
    logic       hlt;
    int         stalls;
    int         halts;
    logic       tmo;
    int         instr;
    int         stall_after;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_instr, m_stall;
  logic m_tmo;
  bit   mon_en   = 0;
  bit   tx_done  = 0;
  int   cyc_stall = 0;
  int   cyc_halt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Monitor: per-cycle state checks, pops one record per pc_en strobe.
  always @(negedge sys_clock) begin
    if (!mon_en) begin
      cyc_stall = 0;
      cyc_halt  = 0;
    end else begin
      if (state_o == 3'd0)
        chk("fetch_zero", {pc_en, do_jump, w_en, alu_op_sel, alu_src, reg_write_src,
                           data_mem_req, data_mem_w_en, halted}, '0);
      if (state_o == 3'd2 || state_o == 3'd3) cyc_stall++;
      if (state_o == 3'd5) begin
        cyc_halt++;
        chk("halt_flag", halted, 1);
      end
      if (q.size() > 0 && state_o >= 3'd1 && state_o <= 3'd4)
        chk("alu_steer", {alu_op_sel, alu_src}, {q[0].alu, q[0].src});
      if (q.size() > 0 && state_o == 3'd2)
        chk("mem_wait_outs", {data_mem_req, data_mem_w_en, w_en, pc_en},
            {1'b1, q[0].op == 4'd13, 1'b0, 1'b0});
      if (pc_en) begin
        if (q.size() == 0) begin
          chk("unexpected_pc_en", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("retire_ctl", {do_jump, w_en, reg_write_src, halted, data_mem_w_en},
              {e.jump, e.wen, e.rws, e.hlt, 1'b0});
          chk("stall_cycles", cyc_stall, e.stalls);
          chk("halt_cycles", cyc_halt, e.halts);
          chk("wait_timeout", wait_timeout, e.tmo);
          chk("instr_count", instr_count, e.instr);
          chk("stall_count", stall_count, e.stall_after);
        end
        cyc_stall = 0;
        cyc_halt  = 0;
        tx_done   = 1;
      end
    end
  end

  // Called one step after a rising edge with the DUT in FETCH.
  task automatic issue(input logic [3:0] op, input logic [3:0] fn, input logic zf,
                       input logic [1:0] es, input int mdel, input int evc, input int hcyc);
    exp_t e;
    int   st;
    int   c;
    st = 0;
    if (op == 4'd13 || op == 4'd14) st = mdel + 1;
    else if (op == 4'd7) begin
      if (es >= NEV || evc == 1) st = 1;
      else if (evc >= 2 && evc <= TMO + 1) st = evc - 1;
      else begin
        st    = TMO;
        m_tmo = 1;
      end
    end
    e.op   = op;
    e.jump = (op == 4'd2) || (op == 4'd3 && zf) || (op == 4'd4 && !zf);
    e.wen  = op inside {4'd1, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14};
    e.rws  = (op == 4'd14) ? 2'b01 : (op == 4'd11) ? 2'b10 : 2'b00;
    case (op)
      4'd1:                      begin e.alu = fn;   e.src = 0; end
      4'd3, 4'd4:                begin e.alu = 4'd1; e.src = 0; end
      4'd8, 4'd10, 4'd13, 4'd14: begin e.alu = 4'd0; e.src = 1; end
      4'd9:                      begin e.alu = 4'd5; e.src = 1; end
      default:                   begin e.alu = 4'd0; e.src = 0; end
    endcase
    e.hlt         = (op == 4'd15);
    e.halts       = e.hlt ? hcyc : 0;
    e.stalls      = st;
    e.tmo         = m_tmo;
    e.instr       = m_instr;
    m_stall       = sat(m_stall + st);
    e.stall_after = m_stall;
    if (!e.hlt) m_instr = sat(m_instr + 1);
    q.push_back(e);

    opcode = op; alu_func = fn; zero_flag = zf; ev_sel = es;
    c = 0;
    while (!tx_done && c < 80) begin
      data_mem_ready = (c >= 2 + mdel);
      resume         = (c >= 1 + hcyc);
      event_pulse    = NEV'($urandom);
      if (es < NEV) event_pulse[es] = (c == evc);
      @(posedge sys_clock); #1;
      c++;
    end
    if (!tx_done) begin
      chk("retire_timeout", 0, 1);
      q.delete();
    end
    tx_done = 0;
  endtask

  // Hold reset across two edges, check the cleared state, release in FETCH.
  task automatic reset_check(input string tag);
    mon_en = 0;
    reset_n = 0; data_mem_ready = 0; resume = 0; event_pulse = '0;
    @(posedge sys_clock);
    @(negedge sys_clock);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_outs"}, {pc_en, do_jump, w_en, alu_op_sel, alu_src, reg_write_src,
                         data_mem_req, data_mem_w_en, halted, wait_timeout}, '0);
    chk({tag, "_counts"}, {instr_count, stall_count}, '0);
    @(posedge sys_clock); #1;
    reset_n = 1;
    m_instr = 0; m_stall = 0; m_tmo = 0;
    q.delete();
    tx_done = 0;
    mon_en  = 1;
  endtask

  task automatic reset_mid(input logic [3:0] op, input logic [2:0] tgt, input string tag);
    mon_en = 0;
    opcode = op; ev_sel = 2'd1; data_mem_ready = 0; resume = 0; event_pulse = '0;
    repeat (4) @(posedge sys_clock);
    #1;
    chk({tag, "_pre_state"}, state_o, tgt);
    reset_check(tag);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; opcode = 0; alu_func = 0; ev_sel = 0; zero_flag = 0;
    event_pulse = '0; data_mem_ready = 0; resume = 0;
    m_instr = 0; m_stall = 0; m_tmo = 0;
    reset_check("por");

    issue(4'd8,  4'd0, 0, 2'd0, 0, 1000, 0);
    issue(4'd14, 4'd0, 0, 2'd0, 3, 1000, 0);
    issue(4'd4,  4'd0, 0, 2'd0, 0, 1000, 0);
    issue(4'd4,  4'd0, 1, 2'd0, 0, 1000, 0);
    issue(4'd7,  4'd0, 0, 2'd1, 0, 1,    0);
    issue(4'd7,  4'd0, 0, 2'd1, 0, 1000, 0);
    issue(4'd7,  4'd0, 0, 2'd0, 0, 11,   0);
    issue(4'd7,  4'd0, 0, 2'd3, 0, 1000, 0);
    issue(4'd15, 4'd0, 0, 2'd0, 0, 1000, 5);
    issue(4'd13, 4'd0, 0, 2'd0, 0, 1000, 0);
    issue(4'd1,  4'd9, 0, 2'd0, 0, 1000, 0);
    issue(4'd11, 4'd0, 0, 2'd0, 0, 1000, 0);
    issue(4'd2,  4'd0, 0, 2'd0, 0, 1000, 0);
    issue(4'd3,  4'd0, 1, 2'd0, 0, 1000, 0);

    reset_mid(4'd14, 3'd2, "rst_mem");
    issue(4'd7, 4'd0, 0, 2'd2, 0, 1000, 0);
    reset_mid(4'd7,  3'd3, "rst_wait");
    reset_mid(4'd15, 3'd5, "rst_halt");

    for (int i = 0; i < 45; i++) begin
      int evc;
      case ($urandom_range(0, 2))
        0:       evc = 1;
        1:       evc = 2 + int'($urandom_range(0, 11));
        default: evc = 1000;
      endcase
      issue(4'($urandom_range(0, 15)), 4'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 4)), evc, int'($urandom_range(1, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
